// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce
// Brief    : 2-flop synchroniser plus tick-based debounce with edge strobes.
// Revision : 1.0
// ============================================================================
module sw_debounce #(
   parameter int WIDTH        = 4,
   parameter int PRESCALE     = 100000,
   parameter int STABLE_TICKS = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             changed
);

   localparam int c_PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int c_CNT_W = $clog2(STABLE_TICKS) + 1;
   localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRESCALE - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_TICKS - 1);

   logic [WIDTH-1:0]   r_meta;
   logic [WIDTH-1:0]   r_sync;
   logic [c_PRE_W-1:0] r_pre;
   logic               w_tick;
   logic [c_CNT_W-1:0] r_cnt     [WIDTH];
   logic [c_CNT_W-1:0] w_cnt_nxt [WIDTH];
   logic [WIDTH-1:0]   w_upd;

   assign w_tick = (r_pre == c_PRE_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
         r_pre  <= '0;
      end else begin
         r_meta <= sw_raw;
         r_sync <= r_meta;
         r_pre  <= w_tick ? '0 : r_pre + c_PRE_W'(1);
      end
   end

   // Any cycle where the input matches the debounced level aborts a pending change.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         w_upd[i]     = 1'b0;
         w_cnt_nxt[i] = r_cnt[i];
         if (r_sync[i] == sw_db[i]) begin
            w_cnt_nxt[i] = '0;
         end else if (w_tick) begin
            if (r_cnt[i] == c_CNT_MAX) begin
               w_upd[i]     = 1'b1;
               w_cnt_nxt[i] = '0;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + c_CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
         sw_db   <= '0;
         sw_rise <= '0;
         sw_fall <= '0;
         changed <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
         sw_db   <= (sw_db & ~w_upd) | (r_sync & w_upd);
         sw_rise <= w_upd & r_sync;
         sw_fall <= w_upd & ~r_sync;
         changed <= |w_upd;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_debounce
// Brief    : Directed and random checks of sw_debounce against a tick-count model.
// Revision : 1.0
// ============================================================================
module tb_sw_debounce;

   localparam int W  = 4;
   localparam int P  = 4;
   localparam int ST = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] sw_raw;
   logic [W-1:0] sw_db;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         changed;

   int checks = 0;
   int errors = 0;

   // reference model state: edge index since reset release, raw history, model levels
   int           n;
   logic [W-1:0] h1, h2, mdb, erise, efall;
   int           eq_edge [W];

   int           n_rise, n_fall, n_chg;
   logic [W-1:0] last_rise, last_fall;
   logic [W-1:0] upd_db, upd_rise, upd_fall;
   logic         upd_chg;
   int           k;

   sw_debounce #(.WIDTH(W), .PRESCALE(P), .STABLE_TICKS(ST)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_raw  (sw_raw),
      .sw_db   (sw_db),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall),
      .changed (changed)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert ((obs >= lo && obs <= hi) === 1'b1) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic model_reset();
      n   = 0;
      h1  = '0;
      h2  = '0;
      mdb = '0;
      for (int i = 0; i < W; i++) eq_edge[i] = 0;
   endtask

   task automatic clear_counts();
      n_rise = 0; n_fall = 0; n_chg = 0;
      last_rise = '0; last_fall = '0;
   endtask

   // One clock: the model decides from tick counts since the input last matched.
   task automatic step();
      logic [W-1:0] s;
      @(posedge clk);
      n++;
      s     = h2;
      erise = '0;
      efall = '0;
      for (int i = 0; i < W; i++) begin
         if (s[i] == mdb[i]) begin
            eq_edge[i] = n;
         end else if ((n % P) == 0 && (n / P - eq_edge[i] / P) == ST) begin
            mdb[i]     = s[i];
            erise[i]   = s[i];
            efall[i]   = ~s[i];
            eq_edge[i] = n;
         end
      end
      h2 = h1;
      h1 = sw_raw;
      #1;
      check("db", {28'd0, sw_db}, {28'd0, mdb});
      check("rise", {28'd0, sw_rise}, {28'd0, erise});
      check("fall", {28'd0, sw_fall}, {28'd0, efall});
      check("changed", {31'd0, changed}, {31'd0, |(erise | efall)});
      if (sw_rise != '0) begin n_rise++; last_rise = sw_rise; end
      if (sw_fall != '0) begin n_fall++; last_fall = sw_fall; end
      if (changed) n_chg++;
   endtask

   task automatic steps(input int cnt);
      for (int j = 0; j < cnt; j++) step();
   endtask

   task automatic wait_change(input logic [W-1:0] mask, output int kk);
      logic [W-1:0] start;
      start = sw_db & mask;
      kk    = 99;
      for (int j = 1; j <= 30; j++) begin
         step();
         if ((sw_db & mask) != start) begin
            kk       = j;
            upd_db   = sw_db;
            upd_rise = sw_rise;
            upd_fall = sw_fall;
            upd_chg  = changed;
            break;
         end
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_db"}, {28'd0, sw_db}, 32'd0);
      check({tag, "_rise"}, {28'd0, sw_rise}, 32'd0);
      check({tag, "_fall"}, {28'd0, sw_fall}, 32'd0);
      check({tag, "_chg"}, {31'd0, changed}, 32'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      sw_raw = '0;
      model_reset();
      clear_counts();
      repeat (3) @(posedge clk);
      #1 check_zero("por");
      #2 rst_n = 1'b1;
      model_reset();
      steps(4);

      // 1: asynchronous reset with all switches on
      sw_raw = 4'b1111;
      steps(20);
      check("pre_rst_db", {28'd0, sw_db}, 32'hf);
      #2 rst_n = 1'b0;
      #1 check_zero("rst_imm");
      for (int j = 0; j < 4; j++) begin
         @(posedge clk);
         #1 check_zero("rst_hold");
      end
      sw_raw = 4'b0000;
      #2 rst_n = 1'b1;
      model_reset();
      steps(5);

      // 2: clean press
      clear_counts();
      sw_raw = 4'b0001;
      wait_change(4'b0001, k);
      check_range("press_lat", k, 11, 15);
      check("press_rise", {28'd0, upd_rise}, 32'h1);
      check("press_chg", {31'd0, upd_chg}, 32'h1);
      steps(10);
      check("press_nrise", n_rise, 1);
      check("press_nchg", n_chg, 1);
      check("press_nfall", n_fall, 0);

      // 3: bouncing bit 1
      clear_counts();
      for (int c = 0; c < 40; c++) begin
         if (c % 3 == 0) sw_raw[1] = ~sw_raw[1];
         step();
      end
      check("bounce_db1", {31'd0, sw_db[1]}, 32'd0);
      check("bounce_nchg", n_chg, 0);
      sw_raw[1] = 1'b1;
      wait_change(4'b0010, k);
      check_range("bounce_lat", k, 1, 15);
      steps(10);
      check("bounce_nrise", n_rise, 1);
      check("bounce_rise", {28'd0, last_rise}, 32'h2);

      // 4: release bit 0
      clear_counts();
      sw_raw = 4'b0010;
      wait_change(4'b0001, k);
      check_range("rel_lat", k, 11, 15);
      check("rel_fall", {28'd0, upd_fall}, 32'h1);
      steps(10);
      check("rel_nfall", n_fall, 1);
      check("rel_nrise", n_rise, 0);

      // 5: simultaneous multi-bit change
      sw_raw = 4'b0100;
      steps(20);
      check("sim_pre_db", {28'd0, sw_db}, 32'h4);
      clear_counts();
      sw_raw = 4'b1010;
      wait_change(4'b1111, k);
      check_range("sim_lat", k, 11, 15);
      check("sim_db", {28'd0, upd_db}, 32'ha);
      check("sim_rise", {28'd0, upd_rise}, 32'ha);
      check("sim_fall", {28'd0, upd_fall}, 32'h4);
      check("sim_chg", {31'd0, upd_chg}, 32'h1);
      step();
      check("sim_chg_next", {31'd0, changed}, 32'd0);
      steps(10);
      check("sim_nchg", n_chg, 1);

      // 6: reset while a change is pending
      sw_raw = 4'b0000;
      steps(20);
      sw_raw = 4'b1000;
      steps(2 * P);
      check("mid_pre_db3", {31'd0, sw_db[3]}, 32'd0);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1 check_zero("mid_rst");
      #2 rst_n = 1'b1;
      model_reset();
      wait_change(4'b1000, k);
      check_range("mid_lat", k, 11, 15);
      check("mid_db3", {31'd0, upd_db[3]}, 32'd1);

      // random stimulus against the model, with one reset midway
      for (int c = 0; c < 800; c++) begin
         int r;
         r = $urandom_range(0, 15);
         if (r == 0) sw_raw = 4'($urandom);
         else if (r == 1) sw_raw = sw_raw ^ 4'(1 << $urandom_range(0, 3));
         if (c == 400) begin
            #2 rst_n = 1'b0;
            #1 check_zero("rnd_rst");
            @(posedge clk);
            #2 rst_n = 1'b1;
            model_reset();
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
